// File: rtl/lsu_mem_arbiter.sv
// Arbitrates per-LSU read/write requests onto a smaller pool of memory channels.
// Each channel owns one consumer from grant until that consumer drops its request.
module lsu_mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 2,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    READ_RELAY,
    WRITE_RELAY
  } state_t;

  state_t                           r_state      [NUM_CHANNELS];
  state_t                           w_state_next [NUM_CHANNELS];
  logic [IW-1:0]                    r_cur        [NUM_CHANNELS];
  logic [IW-1:0]                    w_grant_idx  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]          w_grant;
  logic [NUM_CHANNELS-1:0]          w_grant_rd;
  logic [NUM_CONSUMERS-1:0]         r_claimed;
  logic [NUM_CONSUMERS-1:0]         w_taken;
  logic [NUM_CONSUMERS-1:0]         w_wr_req;
  logic [NUM_CONSUMERS-1:0]         w_req;

  logic [NUM_CONSUMERS-1:0]         r_rd_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] r_rd_data;
  logic [NUM_CONSUMERS-1:0]         r_wr_ready;
  logic [NUM_CHANNELS-1:0]          r_mem_rd_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] r_mem_rd_addr;
  logic [NUM_CHANNELS-1:0]          r_mem_wr_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] r_mem_wr_addr;
  logic [NUM_CHANNELS*DATA_BITS-1:0] r_mem_wr_data;

  generate
    if (WRITE_ENABLE != 0) begin : g_write
      assign w_wr_req             = consumer_write_valid;
      assign consumer_write_ready = r_wr_ready;
      assign mem_write_valid      = r_mem_wr_valid;
      assign mem_write_address    = r_mem_wr_addr;
      assign mem_write_data       = r_mem_wr_data;
    end else begin : g_no_write
      assign w_wr_req             = '0;
      assign consumer_write_ready = '0;
      assign mem_write_valid      = '0;
      assign mem_write_address    = '0;
      assign mem_write_data       = '0;
    end
  endgenerate

  assign w_req               = consumer_read_valid | w_wr_req;
  assign consumer_read_ready = r_rd_ready;
  assign consumer_read_data  = r_rd_data;
  assign mem_read_valid      = r_mem_rd_valid;
  assign mem_read_address    = r_mem_rd_addr;

  // Channels grant in ascending order; each grant is masked from higher channels.
  // The descending scan lets the lowest eligible index win.
  always_comb begin
    w_taken    = r_claimed;
    w_grant    = '0;
    w_grant_rd = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_grant_idx[c] = '0;
      if (r_state[c] == IDLE) begin
        for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
          if (!w_taken[k] && w_req[k]) begin
            w_grant[c]     = 1'b1;
            w_grant_idx[c] = IW'(k);
            w_grant_rd[c]  = consumer_read_valid[k];
          end
        end
        if (w_grant[c]) w_taken[w_grant_idx[c]] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_state_next[c] = r_state[c];
      case (r_state[c])
        IDLE:        if (w_grant[c]) w_state_next[c] = w_grant_rd[c] ? READ_WAIT : WRITE_WAIT;
        READ_WAIT:   if (mem_read_ready[c]) w_state_next[c] = READ_RELAY;
        WRITE_WAIT:  if (mem_write_ready[c]) w_state_next[c] = WRITE_RELAY;
        READ_RELAY:  if (!consumer_read_valid[r_cur[c]]) w_state_next[c] = IDLE;
        WRITE_RELAY: if (!w_wr_req[r_cur[c]]) w_state_next[c] = IDLE;
        default:     w_state_next[c] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) r_state[c] <= IDLE;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) r_state[c] <= w_state_next[c];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_claimed      <= '0;
      r_rd_ready     <= '0;
      r_rd_data      <= '0;
      r_wr_ready     <= '0;
      r_mem_rd_valid <= '0;
      r_mem_rd_addr  <= '0;
      r_mem_wr_valid <= '0;
      r_mem_wr_addr  <= '0;
      r_mem_wr_data  <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) r_cur[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        case (r_state[c])
          IDLE: begin
            if (w_grant[c]) begin
              r_claimed[w_grant_idx[c]] <= 1'b1;
              r_cur[c]                  <= w_grant_idx[c];
              if (w_grant_rd[c]) begin
                r_mem_rd_valid[c] <= 1'b1;
                r_mem_rd_addr[c*ADDR_BITS +: ADDR_BITS] <=
                  consumer_read_address[w_grant_idx[c]*ADDR_BITS +: ADDR_BITS];
              end else begin
                r_mem_wr_valid[c] <= 1'b1;
                r_mem_wr_addr[c*ADDR_BITS +: ADDR_BITS] <=
                  consumer_write_address[w_grant_idx[c]*ADDR_BITS +: ADDR_BITS];
                r_mem_wr_data[c*DATA_BITS +: DATA_BITS] <=
                  consumer_write_data[w_grant_idx[c]*DATA_BITS +: DATA_BITS];
              end
            end
          end
          READ_WAIT: begin
            if (mem_read_ready[c]) begin
              r_mem_rd_valid[c] <= 1'b0;
              r_rd_data[r_cur[c]*DATA_BITS +: DATA_BITS] <= mem_read_data[c*DATA_BITS +: DATA_BITS];
              r_rd_ready[r_cur[c]] <= 1'b1;
            end
          end
          WRITE_WAIT: begin
            if (mem_write_ready[c]) begin
              r_mem_wr_valid[c]    <= 1'b0;
              r_wr_ready[r_cur[c]] <= 1'b1;
            end
          end
          READ_RELAY: begin
            if (!consumer_read_valid[r_cur[c]]) begin
              r_rd_ready[r_cur[c]] <= 1'b0;
              r_claimed[r_cur[c]]  <= 1'b0;
            end
          end
          WRITE_RELAY: begin
            if (!w_wr_req[r_cur[c]]) begin
              r_wr_ready[r_cur[c]] <= 1'b0;
              r_claimed[r_cur[c]]  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/lsu_mem_arbiter.md
Name: lsu_mem_arbiter

Overview:
- Sits directly downstream of the compute cores' data-memory ports.
- Arbitrates NUM_CONSUMERS per-thread LSU request channels (read and write) onto NUM_CHANNELS physical data-memory channels.
- Holds a valid/ready handshake with each LSU on one side and with the memory on the other.
- Returns read data and write acknowledgements to the requesting LSU, then releases the channel once the LSU drops its request.

Parameters:
- ADDR_BITS, 8, data memory address width.
- DATA_BITS, 8, data memory word width.
- NUM_CONSUMERS, 8, number of LSU request ports (cores × threads per block).
- NUM_CHANNELS, 2, number of concurrent memory channels; must satisfy 1 ≤ NUM_CHANNELS ≤ NUM_CONSUMERS.
- WRITE_ENABLE, 1, when 0 all write logic is removed and write outputs are tied to 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- consumer_read_valid  input  NUM_CONSUMERS  per-LSU read request.
- consumer_read_address  input  NUM_CONSUMERS × ADDR_BITS  read address per LSU.
- consumer_read_ready  output  NUM_CONSUMERS  read completion per LSU.
- consumer_read_data  output  NUM_CONSUMERS × DATA_BITS  returned read data per LSU.
- consumer_write_valid  input  NUM_CONSUMERS  per-LSU write request.
- consumer_write_address  input  NUM_CONSUMERS × ADDR_BITS  write address per LSU.
- consumer_write_data  input  NUM_CONSUMERS × DATA_BITS  write data per LSU.
- consumer_write_ready  output  NUM_CONSUMERS  write completion per LSU.
- mem_read_valid  output  NUM_CHANNELS  read request per memory channel.
- mem_read_address  output  NUM_CHANNELS × ADDR_BITS  read address per channel.
- mem_read_ready  input  NUM_CHANNELS  memory read done per channel.
- mem_read_data  input  NUM_CHANNELS × DATA_BITS  memory read data per channel.
- mem_write_valid  output  NUM_CHANNELS  write request per channel.
- mem_write_address  output  NUM_CHANNELS × ADDR_BITS  write address per channel.
- mem_write_data  output  NUM_CHANNELS × DATA_BITS  write data per channel.
- mem_write_ready  input  NUM_CHANNELS  memory write done per channel.

Behaviour:
- Reset (asynchronous, active-high), taking effect immediately including mid-transaction:
  - all outputs go to 0;
  - every channel returns to IDLE;
  - the claimed mask (NUM_CONSUMERS bits) clears;
  - in-flight memory transactions are abandoned.
- Per-channel FSM: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
- IDLE:
  - The channel scans consumers from index 0 upward.
  - It picks the lowest index k that is not claimed, not granted this cycle by a lower-numbered channel, and has read_valid or write_valid set.
  - If both are set on k, read takes priority.
  - At the edge: claim k, latch k as current_consumer, and drive the mem_*_valid/address/data registers from consumer k.
  - Next state is READ_WAIT or WRITE_WAIT.
  - Channels are evaluated in ascending order within one cycle, so channel c never grants a consumer granted by channel c' < c in the same cycle.
- READ_WAIT:
  - Hold mem_read_valid=1 and a stable address until mem_read_ready=1.
  - At that edge: mem_read_valid←0, consumer_read_data[k]←mem_read_data[c], consumer_read_ready[k]←1, next state READ_RELAY.
- WRITE_WAIT:
  - Same as READ_WAIT, using mem_write_ready.
  - At the completing edge: mem_write_valid←0, consumer_write_ready[k]←1, next state WRITE_RELAY.
- READ_RELAY / WRITE_RELAY:
  - Hold ready[k]=1 until consumer valid[k]=0.
  - At that edge: ready[k]←0, release the claim on k, next state IDLE.
  - The channel is eligible to grant again on the following cycle, so minimum occupancy is 3 cycles with zero-latency memory.
- consumer_read_data[k] holds its last value until the next completed read to k.
- Latency:
  - request visible at edge t means mem_*_valid is high from edge t+1;
  - memory ready sampled at edge m means consumer ready is high from edge m+1.
- Boundary conditions:
  - More requesters than channels: the surplus waits with valid held; none are dropped.
  - An unclaimed consumer whose valid drops before grant is never issued.
  - A consumer toggling valid while claimed has no effect until its relay phase.
  - The claimed mask guarantees each consumer is served by at most one channel at a time.
- WRITE_ENABLE=0: write requests are ignored; consumer_write_ready and mem_write_* are constant 0.

Test Plan:
1. Single read: consumer 3 reads addr 0x42, memory returns 0xA5 with 1-cycle ready.
   - mem_read_valid[0] rises one cycle after request, address 0x42.
   - consumer_read_ready[3]=1 with data 0xA5.
   - After consumer_read_valid[3] drops, ready clears next edge and channel 0 returns to IDLE.
2. Parallel grants: consumers 0, 1, 2 all request reads in the same cycle with 2 channels.
   - Channel 0 serves consumer 0 and channel 1 serves consumer 1.
   - Consumer 2 is granted only after one channel completes its relay; no consumer is double-issued.
3. Write path: consumer 5 writes 0x7E to 0x10, memory ready delayed 4 cycles.
   - mem_write_* stays stable for all 4 cycles.
   - consumer_write_ready[5] pulses and is held until its valid drops.
4. Read/write collision: consumer 1 asserts read and write together.
   - The read is serviced first; the write is granted in a later IDLE cycle.
5. Reset mid-operation: assert reset while channel 0 is in READ_WAIT.
   - All outputs are 0 immediately and the claimed mask is 0.
   - After release, a fresh request from consumer 0 completes normally.
6. Stress: 8 consumers, random memory latency 0–5, 500 transactions.
   - A scoreboard confirms every request completes exactly once with correct data and no channel ever carries two consumers.
